dwt_octave_sched: RTL and testbench
===================================

// Module: dwt_octave_sched
// PURPOSE
//  Time-shares one pipelined DB4 lattice core (even/odd in, g/h out) across
//  LEVELS octaves of a Mallat pyramid DWT. Pairs input samples into even/odd,
//  issues one pair per clk to the core, and feeds each level's g result back
//  as the next level's input. Emits h for every level and g for the last level.
// PARAMETERS
//  DW       8  input/feedback sample width (signed)
//  OW       9  core g/h output width (signed)
//  LEVELS   3  octaves, 1..7
//  CORE_LAT 2  edges from sampled core_issue to valid core_g/core_h
// PORTS
//  clk        in  1   system clock
//  reset      in  1   asynchronous, active-high
//  x_in       in  DW  level-0 sample
//  x_valid    in  1   x_in valid this cycle
//  core_ready in  1   core accepts an issue this cycle
//  core_issue out 1   pair presented to core (registered)
//  core_xe    out DW  even sample of issued pair
//  core_xo    out DW  odd sample of issued pair
//  core_g     in  OW  core lowpass result
//  core_h     in  OW  core highpass result
//  h_out      out OW  highpass coefficient
//  h_level    out 3   octave of h_out (0 = finest)
//  h_valid    out 1   h_out valid, 1-cycle pulse
//  g_out      out OW  lowpass coefficient of level LEVELS-1
//  g_valid    out 1   g_out valid, 1-cycle pulse
//  busy       out 1   any slot non-EMPTY or any result in flight
//  ovf        out 1   sticky overflow; cleared only by reset
// BEHAVIOUR
//  - Reset (async): all outputs 0, slots EMPTY, tag pipe cleared; in-flight results dropped.
//  - Per-level slot FSM: EMPTY -(sample)-> HAVE_EVEN -(sample)-> PAIR_READY
//    -(issued)-> EMPTY. 1st sample = even (core_xe), 2nd = odd (core_xo).
//  - Level 0 sample source: x_in when x_valid; level L>0: core g result of level L-1.
//  - Issue: if core_ready, lowest-index PAIR_READY slot issued at next edge;
//    core_issue/core_xe/core_xo registered; core_issue=0 when nothing issued.
//  - One issue per clk max; core_ready=0 holds all PAIR_READY slots.
//  - Tag pipe (valid+level) CORE_LAT deep, shifts every clk; core_g/core_h sampled
//    when tag emerges; core never stalls its pipe.
//  - At tag emergence (edge E), level L: h_out<=core_h, h_level<=L, h_valid=1 in
//    cycle after E. L<LEVELS-1: sat(core_g) to DW (clip to -2^(DW-1)..2^(DW-1)-1) and
//    write as sample into slot L+1 at edge E. L=LEVELS-1: g_out<=core_g, g_valid=1 with h.
//  - Latency: pair completed at edge k, core_ready=1, no higher-priority slot ->
//    core_issue high after k+1; h_valid high after k+1+CORE_LAT+1.
//  - Same-edge issue and new sample on one slot: slot -> HAVE_EVEN, new sample = even.
//  - Sample into PAIR_READY slot not issued that edge: sample dropped, ovf<=1, slot unchanged.
//  - x_valid and feedback same edge target different slots; both accepted.
// TESTING (bench core model: g=xe+xo, h=xe-xo, CORE_LAT=2, LEVELS=3)
//  1 reset asserted mid-run -> all outputs 0, busy=0; next x pairs restart at level 0.
//  2 x=10,20 on consecutive x_valid, core_ready=1 -> core_issue xe=10 xo=20; h_out=-10 lvl0.
//  3 8 samples of 1 -> 4 h lvl0 (0), 2 h lvl1 (0), 1 h lvl2 (0), one g_out=8.
//  4 x=100,100 -> core_g=200 fed back saturated: level-1 even sample = 127.
//  5 level0 and level1 both PAIR_READY same cycle -> lvl0 issued first, lvl1 next clk.
//  6 core_ready=0, feed 3 samples -> 3rd hits PAIR_READY slot: ovf=1, stays 1 after ready.

Source files
------------

// File: rtl/dwt_octave_sched.sv
// -----------------------------------------------------------------------------
// dwt_octave_sched
//   Time-shares one pipelined DB4 lattice core across LEVELS octaves of a
//   Mallat pyramid DWT. Each octave has a slot that collects two samples
//   (even, then odd). Ready pairs are issued to the core, at most one per clk,
//   and the lowest octave wins. A tag pipe follows each issue through the core.
//   When a tag emerges, h is always emitted. The g result is either
//   saturated and written back as the next octave's sample, or, for the last
//   octave, emitted on g_out.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   x_in, x_valid       level-0 input samples
//   core_ready          core accepts an issue this cycle
//   core_issue/xe/xo    registered pair presented to the core
//   core_g, core_h      core results, CORE_LAT edges after the issue is sampled
//   h_out/h_level/h_valid  highpass coefficient, its octave, 1-cycle strobe
//   g_out/g_valid       lowpass coefficient of the last octave, 1-cycle strobe
//   busy                any slot occupied or any result in flight
//   ovf                 sticky: a sample arrived at a full, un-issued slot
// -----------------------------------------------------------------------------
module dwt_octave_sched #(
    parameter int DW       = 8,
    parameter int OW       = 9,
    parameter int LEVELS   = 3,
    parameter int CORE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] x_in,
    input  logic                 x_valid,
    input  logic                 core_ready,
    output logic                 core_issue,
    output logic signed [DW-1:0] core_xe,
    output logic signed [DW-1:0] core_xo,
    input  logic signed [OW-1:0] core_g,
    input  logic signed [OW-1:0] core_h,
    output logic signed [OW-1:0] h_out,
    output logic [2:0]           h_level,
    output logic                 h_valid,
    output logic signed [OW-1:0] g_out,
    output logic                 g_valid,
    output logic                 busy,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_HAVE_EVEN,
        SLOT_PAIR_READY
    } slot_state_e;

    localparam int SAT_MAX = (1 << (DW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DW - 1));

    // Clip a core result to the sample width before it is fed back.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [OW-1:0] v);
        if (int'(v) > SAT_MAX) return DW'(SAT_MAX);
        if (int'(v) < SAT_MIN) return DW'(SAT_MIN);
        return v[DW-1:0];
    endfunction

    slot_state_e          slot_q [LEVELS];
    slot_state_e          slot_d [LEVELS];
    logic signed [DW-1:0] even_q [LEVELS];
    logic signed [DW-1:0] even_d [LEVELS];
    logic signed [DW-1:0] odd_q  [LEVELS];
    logic signed [DW-1:0] odd_d  [LEVELS];

    logic                 samp_v [LEVELS];
    logic signed [DW-1:0] samp   [LEVELS];

    logic                 issue_go;
    logic [2:0]           issue_lvl;
    logic signed [DW-1:0] issue_xe, issue_xo;

    logic                 core_issue_q;
    logic [2:0]           issue_lvl_q;
    logic signed [DW-1:0] core_xe_q, core_xo_q;

    logic                 tag_vld_q [CORE_LAT];
    logic [2:0]           tag_lvl_q [CORE_LAT];

    logic                 emerge, fb_valid, ovf_hit;
    logic [2:0]           emerge_lvl;
    logic signed [DW-1:0] fb_data;

    logic signed [OW-1:0] h_out_q, g_out_q;
    logic [2:0]           h_level_q;
    logic                 h_valid_q, g_valid_q, ovf_q;

    // The tag leaving the pipe marks the cycle in which core_g/core_h belong to it.
    assign emerge     = tag_vld_q[CORE_LAT-1];
    assign emerge_lvl = tag_lvl_q[CORE_LAT-1];
    assign fb_valid   = emerge && (emerge_lvl != 3'(LEVELS - 1));
    assign fb_data    = sat_dw(core_g);

    // Priority pick: scanning downward means the lowest ready octave is written last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        issue_go  = 1'b0;
        issue_lvl = '0;
        issue_xe  = '0;
        issue_xo  = '0;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_PAIR_READY) begin
                issue_go  = core_ready;
                issue_lvl = 3'(i);
                issue_xe  = even_q[i];
                issue_xo  = odd_q[i];
            end
        end
    end

    // Sample routing: level 0 takes x_in, level L takes the feedback from level L-1.
    always_comb begin
        samp_v[0] = x_valid;
        samp[0]   = x_in;
        for (int i = 1; i < LEVELS; i++) begin
            samp_v[i] = fb_valid && (emerge_lvl == 3'(i - 1));
            samp[i]   = fb_data;
        end
    end

    always_comb begin
        ovf_hit = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            slot_d[i] = slot_q[i];
            even_d[i] = even_q[i];
            odd_d[i]  = odd_q[i];
            unique case (slot_q[i])
                SLOT_EMPTY: begin
                    if (samp_v[i]) begin
                        slot_d[i] = SLOT_HAVE_EVEN;
                        even_d[i] = samp[i];
                    end
                end
                SLOT_HAVE_EVEN: begin
                    if (samp_v[i]) begin
                        slot_d[i] = SLOT_PAIR_READY;
                        odd_d[i]  = samp[i];
                    end
                end
                SLOT_PAIR_READY: begin
                    if (issue_go && issue_lvl == 3'(i)) begin
                        // A sample arriving on the issue edge starts the next pair.
                        slot_d[i] = samp_v[i] ? SLOT_HAVE_EVEN : SLOT_EMPTY;
                        if (samp_v[i]) even_d[i] = samp[i];
                    end else if (samp_v[i]) begin
                        ovf_hit = 1'b1;
                    end
                end
                default: slot_d[i] = SLOT_EMPTY;
            endcase
        end
    end

    always_comb begin
        busy = core_issue_q;
        for (int i = 0; i < LEVELS; i++)   busy = busy | (slot_q[i] != SLOT_EMPTY);
        for (int i = 0; i < CORE_LAT; i++) busy = busy | tag_vld_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the slot arrays are a few flops, not a RAM, so they are reset like any other state.
            for (int i = 0; i < LEVELS; i++) begin
                slot_q[i] <= SLOT_EMPTY;
                even_q[i] <= '0;
                odd_q[i]  <= '0;
            end
            for (int i = 0; i < CORE_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_lvl_q[i] <= '0;
            end
            core_issue_q <= 1'b0;
            issue_lvl_q  <= '0;
            core_xe_q    <= '0;
            core_xo_q    <= '0;
            h_out_q      <= '0;
            h_level_q    <= '0;
            h_valid_q    <= 1'b0;
            g_out_q      <= '0;
            g_valid_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < LEVELS; i++) begin
                slot_q[i] <= slot_d[i];
                even_q[i] <= even_d[i];
                odd_q[i]  <= odd_d[i];
            end
            tag_vld_q[0] <= core_issue_q;
            tag_lvl_q[0] <= issue_lvl_q;
            for (int i = 1; i < CORE_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_lvl_q[i] <= tag_lvl_q[i-1];
            end
            core_issue_q <= issue_go;
            if (issue_go) begin
                issue_lvl_q <= issue_lvl;
                core_xe_q   <= issue_xe;
                core_xo_q   <= issue_xo;
            end
            h_valid_q <= emerge;
            g_valid_q <= emerge && !fb_valid;
            if (emerge) begin
                h_out_q   <= core_h;
                h_level_q <= emerge_lvl;
                if (!fb_valid) g_out_q <= core_g;
            end
            ovf_q <= ovf_q | ovf_hit;
        end
    end

    assign core_issue = core_issue_q;
    assign core_xe    = core_xe_q;
    assign core_xo    = core_xo_q;
    assign h_out      = h_out_q;
    assign h_level    = h_level_q;
    assign h_valid    = h_valid_q;
    assign g_out      = g_out_q;
    assign g_valid    = g_valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_dwt_octave_sched.sv
// -----------------------------------------------------------------------------
// tb_dwt_octave_sched
//   Bench for dwt_octave_sched with a toy core (g = xe+xo, h = xe-xo, two
//   register stages). The reference model is a plain pyramid. Each octave
//   pairs its samples in arrival order, queues h = a-b, and forwards sat(a+b)
//   to the next octave. For the last octave, a+b goes to the g queue. The
//   compare process matches every h_valid/g_valid strobe against those
//   queues. Directed sections pin latency, priority, saturation and overflow
//   with literal values.
// -----------------------------------------------------------------------------
module tb_dwt_octave_sched;

    localparam int DW = 8, OW = 9, LEVELS = 3, CORE_LAT = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] x_in;
    logic                 x_valid, core_ready;
    logic                 core_issue;
    logic signed [DW-1:0] core_xe, core_xo;
    logic signed [OW-1:0] core_g, core_h;
    logic signed [OW-1:0] h_out, g_out;
    logic [2:0]           h_level;
    logic                 h_valid, g_valid, busy, ovf;

    dwt_octave_sched #(.DW(DW), .OW(OW), .LEVELS(LEVELS), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .core_ready(core_ready), .core_issue(core_issue), .core_xe(core_xe),
        .core_xo(core_xo), .core_g(core_g), .core_h(core_h), .h_out(h_out),
        .h_level(h_level), .h_valid(h_valid), .g_out(g_out), .g_valid(g_valid),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Toy core: results appear CORE_LAT edges after the issue is sampled.
    logic signed [OW-1:0] pg [CORE_LAT];
    logic signed [OW-1:0] ph [CORE_LAT];
    always @(posedge clk) begin
        pg[0] <= OW'(int'(core_xe) + int'(core_xo));
        ph[0] <= OW'(int'(core_xe) - int'(core_xo));
        for (int i = 1; i < CORE_LAT; i++) begin
            pg[i] <= pg[i-1];
            ph[i] <= ph[i-1];
        end
    end
    assign core_g = pg[CORE_LAT-1];
    assign core_h = ph[CORE_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural pyramid model ----------------
    bit pend_v [LEVELS];
    int pend_d [LEVELS];
    int hq [LEVELS][$];
    int gq [$];
    int hcount [LEVELS];
    int gcount, last_g;

    typedef struct {
        int xe;
        int xo;
        int cyc;
    } issue_t;
    issue_t ilog [$];
    int cyc_n = 0;

    function automatic int sat_dw(input int v);
        if (v > (1 << (DW - 1)) - 1) return (1 << (DW - 1)) - 1;
        if (v < -(1 << (DW - 1)))    return -(1 << (DW - 1));
        return v;
    endfunction

    task automatic model_push(input int v);
        int  lvl  = 0;
        int  val  = v;
        bit  done = 1'b0;
        while (!done) begin
            if (!pend_v[lvl]) begin
                pend_v[lvl] = 1'b1;
                pend_d[lvl] = val;
                done = 1'b1;
            end else begin
                pend_v[lvl] = 1'b0;
                hq[lvl].push_back(pend_d[lvl] - val);
                if (lvl == LEVELS - 1) begin
                    gq.push_back(pend_d[lvl] + val);
                    done = 1'b1;
                end else begin
                    val = sat_dw(pend_d[lvl] + val);
                    lvl++;
                end
            end
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < LEVELS; l++) begin
            pend_v[l] = 1'b0;
            hq[l].delete();
            hcount[l] = 0;
        end
        gq.delete();
        ilog.delete();
        gcount = 0;
        last_g = 0;
    endtask

    function automatic int model_pending();
        int p = 0;
        for (int l = 0; l < LEVELS; l++) if (pend_v[l]) p = 1;
        return p;
    endfunction

    // ---------------- compare process ----------------
    int cmp_lvl;
    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (!reset) begin
            if (core_issue) ilog.push_back('{int'(core_xe), int'(core_xo), cyc_n});
            if (h_valid) begin
                cmp_lvl = int'(h_level);
                if (cmp_lvl < LEVELS && hq[cmp_lvl].size() > 0) begin
                    check("h_vs_model", int'(h_out), hq[cmp_lvl].pop_front());
                    hcount[cmp_lvl]++;
                end else begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL h_unexpected: got h_out=%0d level=%0d, expected no strobe",
                             h_out, h_level);
                end
            end
            check("g_valid_align", int'(g_valid), int'(h_valid && h_level == 3'(LEVELS - 1)));
            if (g_valid) begin
                if (gq.size() > 0) begin
                    check("g_vs_model", int'(g_out), gq.pop_front());
                    gcount++;
                    last_g = int'(g_out);
                end else begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL g_unexpected: got g_out=%0d, expected no strobe", g_out);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rand_ready = 1'b0;
    int low_run    = 0;

    task automatic tick();
        @(negedge clk);
        if (rand_ready) begin
            if (low_run < 2 && $urandom_range(0, 2) == 0) begin
                core_ready = 1'b0;
                low_run++;
            end else begin
                core_ready = 1'b1;
                low_run = 0;
            end
        end
    endtask

    task automatic send(input int v);
        x_valid = 1'b1;
        x_in    = DW'(v);
        model_push(v);
        tick();
    endtask

    task automatic drain(input int n);
        x_valid = 1'b0;
        repeat (n) tick();
        for (int l = 0; l < LEVELS; l++) check($sformatf("drain_h%0d", l), hq[l].size(), 0);
        check("drain_g", gq.size(), 0);
        check("busy_settled", int'(busy), model_pending());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_issue"}, int'(core_issue), 0);
        check({tag, "_core_xe"}, int'(core_xe), 0);
        check({tag, "_core_xo"}, int'(core_xo), 0);
        check({tag, "_h_out"}, int'(h_out), 0);
        check({tag, "_h_level"}, int'(h_level), 0);
        check({tag, "_h_valid"}, int'(h_valid), 0);
        check({tag, "_g_out"}, int'(g_out), 0);
        check({tag, "_g_valid"}, int'(g_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        x_valid = 1'b0;
        model_clear();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Pair 10,20 from an empty level 0: issue one edge after completion, h three edges later.
    task automatic pair_latency_test(input string tag);
        send(10);
        send(20);
        x_valid = 1'b0;
        check({tag, "_issue_not_early"}, int'(core_issue), 0);
        tick();
        check({tag, "_issue"}, int'(core_issue), 1);
        check({tag, "_xe"}, int'(core_xe), 10);
        check({tag, "_xo"}, int'(core_xo), 20);
        tick();
        tick();
        check({tag, "_h_not_early"}, int'(h_valid), 0);
        tick();
        check({tag, "_h_valid"}, int'(h_valid), 1);
        check({tag, "_h_out"}, int'(h_out), -10);
        check({tag, "_h_level"}, int'(h_level), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        x_valid    = 1'b0;
        x_in       = '0;
        core_ready = 1'b1;
        model_clear();
        repeat (3) tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();

        // Basic pair and latency.
        pair_latency_test("pair");
        drain(40);

        // Eight ones: 4/2/1 zero highpass terms and a single lowpass 8.
        do_reset();
        repeat (8) send(1);
        drain(40);
        check("ones_h0", hcount[0], 4);
        check("ones_h1", hcount[1], 2);
        check("ones_h2", hcount[2], 1);
        check("ones_gcnt", gcount, 1);
        check("ones_g", last_g, 8);

        // Saturated feedback: 100+100 enters level 1 as 127.
        do_reset();
        send(100); send(100); send(1); send(1);
        drain(40);
        check("sat_issue_cnt", ilog.size(), 3);
        if (ilog.size() >= 3) begin
            check("sat_lvl1_xe", ilog[2].xe, 127);
            check("sat_lvl1_xo", ilog[2].xo, 2);
        end

        // Priority: level 0 and level 1 both ready at the same edge.
        do_reset();
        for (int i = 1; i <= 8; i++) send(i);
        drain(40);
        check("prio_issue_cnt", ilog.size(), 7);
        if (ilog.size() >= 5) begin
            check("prio_lvl0_xe", ilog[3].xe, 7);
            check("prio_lvl0_xo", ilog[3].xo, 8);
            check("prio_lvl1_xe", ilog[4].xe, 3);
            check("prio_lvl1_xo", ilog[4].xo, 7);
            check("prio_next_clk", ilog[4].cyc - ilog[3].cyc, 1);
        end

        // Overflow: third sample lands on a held pair and is dropped.
        do_reset();
        core_ready = 1'b0;
        send(5);
        send(9);
        check("ovf_before", int'(ovf), 0);
        x_valid = 1'b1;
        x_in    = DW'(77);
        tick();
        x_valid = 1'b0;
        check("ovf_set", int'(ovf), 1);
        check("ovf_held_issue", int'(core_issue), 0);
        check("ovf_busy", int'(busy), 1);
        core_ready = 1'b1;
        drain(40);
        check("ovf_sticky", int'(ovf), 1);
        if (ilog.size() >= 1) begin
            check("ovf_pair_xe", ilog[0].xe, 5);
            check("ovf_pair_xo", ilog[0].xo, 9);
        end else begin
            check("ovf_pair_issued", ilog.size(), 1);
        end

        // Random stream with the core always ready.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) send($urandom_range(0, 255) - 128);
            else begin
                x_valid = 1'b0;
                tick();
            end
        end
        drain(40);
        check("rand_a_ovf", int'(ovf), 0);

        // Sparse random stream with short random core stalls.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 255) - 128);
            x_valid = 1'b0;
            repeat (7) tick();
        end
        drain(40);
        rand_ready = 1'b0;
        core_ready = 1'b1;
        check("rand_b_ovf", int'(ovf), 0);

        // Reset in the middle of activity, then restart at level 0.
        do_reset();
        for (int i = 0; i < 13; i++) send($urandom_range(0, 255) - 128);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        model_clear();
        tick();
        tick();
        reset   = 1'b0;
        x_valid = 1'b0;
        tick();
        pair_latency_test("restart");
        drain(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
